// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer for a 16x4 single-port RAM: arbitrates one push or pop at a
// time and registers every RAM pin, returning popped words one cycle later.
module ram_fifo_ctrl #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              In_Valid,
  input  logic [WIDTH-1:0]  In_Data,
  output logic              In_Ready,
  input  logic              Rd_Req,
  output logic              Rd_Ack,
  output logic [WIDTH-1:0]  Out_Data,
  output logic              Out_Valid,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic [WIDTH-1:0]  Mem_Data,
  output logic              Mem_RD,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Address,
  input  logic [WIDTH-1:0]  Mem_Output
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_last_wr;
  logic [WIDTH-1:0]    r_mem_data;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_wr;
  logic                r_mem_rd;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;

  logic                w_idle;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_grant_wr;
  logic                w_grant_rd;
  logic [ADDR_W:0]     w_count_nxt;

  // On a tie the op not taken last time wins, so neither side can starve.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_wr_ok    = In_Valid & ~r_full;
  assign w_rd_ok    = Rd_Req & ~r_empty;
  assign w_grant_wr = w_idle & w_wr_ok & ~(w_rd_ok & r_last_wr);
  assign w_grant_rd = w_idle & w_rd_ok & ~(w_wr_ok & ~r_last_wr);

  assign In_Ready = Reset_n & w_idle & ~r_full & ~(w_rd_ok & r_last_wr);
  assign Rd_Ack   = Reset_n & w_idle & w_rd_ok & ~(w_wr_ok & ~r_last_wr);

  always_comb begin
    w_count_nxt = r_count;
    if (w_grant_wr)
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    else if (w_grant_rd)
      w_count_nxt = r_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_last_wr   <= 1'b0;
      r_mem_data  <= '0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      case (r_state)
        ST_IDLE: begin
          if (w_grant_wr) begin
            r_mem_addr <= r_wr_ptr;
            r_mem_data <= In_Data;
            r_mem_wr   <= 1'b1;
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_last_wr  <= 1'b1;
            r_state    <= ST_WRITE;
          end else if (w_grant_rd) begin
            r_mem_addr <= r_rd_ptr;
            r_mem_rd   <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_last_wr  <= 1'b0;
            r_state    <= ST_READ;
          end
        end
        ST_WRITE: begin
          r_mem_wr <= 1'b0;
          r_state  <= ST_IDLE;
        end
        ST_READ: begin
          // RAM output is combinational while RD is high; capture it here.
          r_out_data  <= Mem_Output;
          r_out_valid <= 1'b1;
          r_mem_rd    <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Full        = r_full;
  assign Empty       = r_empty;
  assign Count       = r_count;
  assign Mem_Data    = r_mem_data;
  assign Mem_RD      = r_mem_rd;
  assign Mem_WR      = r_mem_wr;
  assign Mem_Address = r_mem_addr;
  assign Out_Data    = r_out_data;
  assign Out_Valid   = r_out_valid;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x4 RAM attached to
// its memory pins.
module tb_ram_fifo_ctrl;

  logic       Clock;
  logic       Reset_n;
  logic       In_Valid;
  logic [3:0] In_Data;
  logic       In_Ready;
  logic       Rd_Req;
  logic       Rd_Ack;
  logic [3:0] Out_Data;
  logic       Out_Valid;
  logic       Full;
  logic       Empty;
  logic [4:0] Count;
  logic [3:0] Mem_Data;
  logic       Mem_RD;
  logic       Mem_WR;
  logic [3:0] Mem_Address;
  logic [3:0] Mem_Output;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ram [0:15];

  ram_fifo_ctrl #(.WIDTH(4), .ADDR_W(4), .DEPTH(16)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .In_Valid    (In_Valid),
    .In_Data     (In_Data),
    .In_Ready    (In_Ready),
    .Rd_Req      (Rd_Req),
    .Rd_Ack      (Rd_Ack),
    .Out_Data    (Out_Data),
    .Out_Valid   (Out_Valid),
    .Full        (Full),
    .Empty       (Empty),
    .Count       (Count),
    .Mem_Data    (Mem_Data),
    .Mem_RD      (Mem_RD),
    .Mem_WR      (Mem_WR),
    .Mem_Address (Mem_Address),
    .Mem_Output  (Mem_Output)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) if (Mem_WR) ram[Mem_Address] <= Mem_Data;
  assign Mem_Output = Mem_RD ? ram[Mem_Address] : 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in IDLE at least 1 time unit after a rising edge.
  task automatic do_push(input logic [3:0] d, input logic [3:0] exp_addr);
    In_Valid = 1'b1;
    In_Data  = d;
    #1;
    chk("push_in_ready", In_Ready, 1);
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    chk("push_mem_wr", Mem_WR, 1);
    chk("push_mem_rd", Mem_RD, 0);
    chk("push_mem_addr", Mem_Address, exp_addr);
    chk("push_mem_data", Mem_Data, d);
    @(posedge Clock); #1;
    chk("push_mem_wr_off", Mem_WR, 0);
  endtask

  task automatic do_pop(input logic [3:0] exp_addr, input logic [3:0] exp_data);
    Rd_Req = 1'b1;
    #1;
    chk("pop_rd_ack", Rd_Ack, 1);
    @(posedge Clock); #1;
    Rd_Req = 1'b0;
    chk("pop_mem_rd", Mem_RD, 1);
    chk("pop_mem_wr", Mem_WR, 0);
    chk("pop_mem_addr", Mem_Address, exp_addr);
    chk("pop_out_valid_early", Out_Valid, 0);
    @(posedge Clock); #1;
    chk("pop_out_valid", Out_Valid, 1);
    chk("pop_out_data", Out_Data, exp_data);
    chk("pop_mem_rd_off", Mem_RD, 0);
  endtask

  initial begin
    // Reset with hostile inputs
    Reset_n  = 1'b1;
    In_Valid = 1'b1;
    Rd_Req   = 1'b1;
    In_Data  = 4'($urandom_range(15, 0));
    #1 Reset_n = 1'b0;
    #2;
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_count", Count, 0);
    chk("rst_mem_wr", Mem_WR, 0);
    chk("rst_mem_rd", Mem_RD, 0);
    chk("rst_in_ready", In_Ready, 0);
    chk("rst_rd_ack", Rd_Ack, 0);
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_hold_in_ready", In_Ready, 0);
    chk("rst_hold_count", Count, 0);
    chk("rst_hold_out_data", Out_Data, 0);
    In_Valid = 1'b0;
    Rd_Req   = 1'b0;
    #2 Reset_n = 1'b1;
    #1;
    chk("rel_in_ready", In_Ready, 1);
    chk("rel_rd_ack", Rd_Ack, 0);
    @(posedge Clock); #1;

    // Fill with 0..15
    for (int i = 0; i < 16; i++) begin
      do_push(4'(i), 4'(i));
      chk("fill_count", Count, i + 1);
    end
    chk("fill_full", Full, 1);
    chk("fill_empty", Empty, 0);
    In_Valid = 1'b1;
    In_Data  = 4'hA;
    #1;
    chk("full_in_ready", In_Ready, 0);
    repeat (2) @(posedge Clock);
    #1;
    chk("full_no_wr", Mem_WR, 0);
    chk("full_count_held", Count, 16);
    In_Valid = 1'b0;

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      do_pop(4'(i), 4'(i));
      chk("drain_count", Count, 15 - i);
    end
    chk("drain_empty", Empty, 1);
    chk("drain_full", Full, 0);
    Rd_Req = 1'b1;
    #1;
    chk("empty_rd_ack", Rd_Ack, 0);
    @(posedge Clock); #1;
    chk("empty_no_rd", Mem_RD, 0);
    chk("empty_count_held", Count, 0);
    Rd_Req = 1'b0;
    @(posedge Clock); #1;

    // Tie arbitration: one word in, then both sides requesting
    In_Valid = 1'b1;
    In_Data  = 4'h5;
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    chk("tie_pre_wr", Mem_WR, 1);
    @(posedge Clock); #1;
    In_Valid = 1'b1;
    In_Data  = 4'h6;
    Rd_Req   = 1'b1;
    #1;
    chk("tie1_rd_ack", Rd_Ack, 1);
    chk("tie1_in_ready", In_Ready, 0);
    @(posedge Clock); #1;
    chk("tie1_mem_rd", Mem_RD, 1);
    chk("tie1_mem_wr", Mem_WR, 0);
    @(posedge Clock); #1;
    chk("tie1_out_valid", Out_Valid, 1);
    chk("tie1_out_data", Out_Data, 5);
    chk("tie2_in_ready", In_Ready, 1);
    chk("tie2_rd_ack", Rd_Ack, 0);
    @(posedge Clock); #1;
    chk("tie2_mem_wr", Mem_WR, 1);
    chk("tie2_mem_rd", Mem_RD, 0);
    chk("tie2_mem_data", Mem_Data, 6);
    In_Data = 4'h7;
    @(posedge Clock); #1;
    chk("tie3_rd_ack", Rd_Ack, 1);
    chk("tie3_in_ready", In_Ready, 0);
    @(posedge Clock); #1;
    chk("tie3_mem_rd", Mem_RD, 1);
    @(posedge Clock); #1;
    chk("tie3_out_data", Out_Data, 6);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      chk("tie_mutex", Mem_RD & Mem_WR, 0);
    end
    In_Valid = 1'b0;
    Rd_Req   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    // Asynchronous reset in the middle of a write
    In_Valid = 1'b1;
    In_Data  = 4'h3;
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    chk("arst_wr_before", Mem_WR, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_wr_dropped", Mem_WR, 0);
    chk("arst_count", Count, 0);
    #10 Reset_n = 1'b1;
    #1;
    chk("arst_rel_empty", Empty, 1);
    chk("arst_rel_count", Count, 0);
    chk("arst_rel_out_valid", Out_Valid, 0);
    @(posedge Clock); #1;

    // Pointer wrap: 12 in, 12 out, 8 in across the top, 8 out
    for (int i = 0; i < 12; i++) do_push(4'(i), 4'(i));
    for (int i = 0; i < 12; i++) do_pop(4'(i), 4'(i));
    chk("wrap_mid_empty", Empty, 1);
    for (int i = 0; i < 8; i++) do_push(4'(i + 7), 4'(12 + i));
    chk("wrap_count8", Count, 8);
    for (int i = 0; i < 8; i++) do_pop(4'(12 + i), 4'(i + 7));
    chk("wrap_count_end", Count, 0);
    chk("wrap_empty_end", Empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
